// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: segment byte type, common codes and the hex glyph table.
// Bit order is {dp,g,f,e,d,c,b,a}, active-high; pin polarity is applied by each display block.
package seven_seg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'h00;
  localparam seg_t SEG_DP  = 8'h80;

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    seg_t seg;
    case (nibble)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      default: seg = 8'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble plus decimal point to active-high segment byte.
module hex7_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output seg_t       seg
);

  assign seg = hex_to_seg(nibble) | (dp ? SEG_DP : SEG_OFF);

endmodule

// File: rtl/seven_seg_scanner.sv
// N-digit multiplexed 7-segment scanner with per-frame input snapshot, leading-zero
// suppression, per-digit blanking and PWM brightness on the digit select lines.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SLOT_LOG2      = 16,
  parameter int PWM_BITS       = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_suppress,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [DIGITS-1:0]     select,
  output logic [7:0]            segments,
  output logic                  frame_start
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SLOT_LOG2-1:0] slot_ctr;
  logic [IDX_W-1:0]     idx;

  logic [4*DIGITS-1:0]  snap_digits;
  logic [DIGITS-1:0]    snap_dp;
  logic [DIGITS-1:0]    snap_blank;
  logic                 snap_lz;
  logic [PWM_BITS-1:0]  snap_bright;

  logic                 capture_p0;
  logic [4*DIGITS-1:0]  eff_digits_p0;
  logic [DIGITS-1:0]    eff_dp_p0;
  logic [DIGITS-1:0]    eff_blank_p0;
  logic                 eff_lz_p0;
  logic [PWM_BITS-1:0]  eff_bright_p0;
  logic [DIGITS-1:0]    supp_p0;
  logic [DIGITS-1:0]    dark_p0;
  logic                 seen_nz_p0;
  logic [PWM_BITS-1:0]  phase_p0;
  logic                 lit_p0;
  logic [3:0]           nibble_p0;
  logic                 dot_p0;
  seg_t                 dec_seg_p0;
  logic [DIGITS-1:0]    sel_p0;
  seg_t                 seg_p0;

  logic [DIGITS-1:0]    sel_p1;
  seg_t                 seg_p1;
  logic                 frame_p1;

  // Stage p0: counter state, snapshot bypass on the capture cycle, suppression and PWM compare
  assign capture_p0    = (slot_ctr == '0) && (idx == '0);
  assign eff_digits_p0 = capture_p0 ? digits      : snap_digits;
  assign eff_dp_p0     = capture_p0 ? dp          : snap_dp;
  assign eff_blank_p0  = capture_p0 ? blank       : snap_blank;
  assign eff_lz_p0     = capture_p0 ? lz_suppress : snap_lz;
  assign eff_bright_p0 = capture_p0 ? brightness  : snap_bright;

  always_comb begin
    seen_nz_p0 = 1'b0;
    supp_p0    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (eff_digits_p0[4*i +: 4] != 4'h0) seen_nz_p0 = 1'b1;
      supp_p0[i] = eff_lz_p0 && !seen_nz_p0;
    end
  end

  assign dark_p0   = eff_blank_p0 | supp_p0;
  assign phase_p0  = slot_ctr[SLOT_LOG2-1 -: PWM_BITS];
  assign lit_p0    = !dark_p0[idx] && (phase_p0 < eff_bright_p0);
  assign nibble_p0 = eff_digits_p0[4*idx +: 4];
  assign dot_p0    = eff_dp_p0[idx];

  hex7_decode u_hex7_decode (
    .nibble (nibble_p0),
    .dp     (dot_p0),
    .seg    (dec_seg_p0)
  );

  assign sel_p0 = lit_p0 ? (DIGITS'(1) << idx) : '0;
  assign seg_p0 = lit_p0 ? dec_seg_p0 : SEG_OFF;

  // Stage p1: registered pin drive
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_ctr    <= '0;
      idx         <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blank  <= '1;
      snap_lz     <= 1'b0;
      snap_bright <= '0;
      sel_p1      <= '0;
      seg_p1      <= SEG_OFF;
      frame_p1    <= 1'b0;
    end else begin
      slot_ctr <= slot_ctr + 1'b1;
      if (slot_ctr == '1) begin
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end
      if (capture_p0) begin
        snap_digits <= digits;
        snap_dp     <= dp;
        snap_blank  <= blank;
        snap_lz     <= lz_suppress;
        snap_bright <= brightness;
      end
      sel_p1   <= sel_p0;
      seg_p1   <= seg_p0;
      frame_p1 <= capture_p0;
    end
  end

  assign select      = (SEL_ACTIVE_LOW != 0) ? ~sel_p1 : sel_p1;
  assign segments    = (SEG_ACTIVE_LOW != 0) ? ~seg_p1 : seg_p1;
  assign frame_start = frame_p1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised bench for seven_seg_scanner: a frame/slot arithmetic model checked every cycle,
// plus literal expectations at chosen scan positions.
module tb_seven_seg_scanner;

  localparam int DIGITS    = 4;
  localparam int SLOT_LOG2 = 4;
  localparam int PWM_BITS  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_suppress;
  logic [1:0]  brightness;
  logic [3:0]  select;
  logic [7:0]  segments;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int last_c = -1;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  seven_seg_scanner #(
    .DIGITS         (DIGITS),
    .SLOT_LOG2      (SLOT_LOG2),
    .PWM_BITS       (PWM_BITS),
    .SEG_ACTIVE_LOW (1),
    .SEL_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .digits      (digits),
    .dp          (dp),
    .blank       (blank),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .select      (select),
    .segments    (segments),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (scan pos %0d)", name, act, exp, last_c);
    end
  endtask

  task automatic lit(input string name, input logic [3:0] e_sel, input logic [7:0] e_seg,
                     input logic e_fs);
    check({name, ".select"}, 32'(select), 32'(e_sel));
    check({name, ".segments"}, 32'(segments), 32'(e_seg));
    check({name, ".frame_start"}, 32'(frame_start), 32'(e_fs));
  endtask

  task automatic goto(input int target);
    int n;
    n = 0;
    while (last_c != target && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (last_c != target) begin
      checks++;
      errors++;
      $display("FAIL goto_timeout: got %0d expected %0d", last_c, target);
    end
  endtask

  // Model: position c counts clock edges since reset release; slot = c%16, digit = (c/16)%4,
  // a new snapshot is taken whenever c%64 == 0.
  initial begin : model
    int          cnt, c, slot, di;
    logic [15:0] s_dig;
    logic [3:0]  s_dp, s_bl;
    logic        s_lz;
    logic [1:0]  s_br;
    logic        on, supp;
    logic [3:0]  e_sel;
    logic [7:0]  e_seg;
    logic        e_fs;
    cnt = 0;
    s_dig = '0; s_dp = '0; s_bl = '1; s_lz = 1'b0; s_br = '0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        cnt    = 0;
        last_c = -1;
        e_sel  = 4'hF;
        e_seg  = 8'hFF;
        e_fs   = 1'b0;
      end else begin
        c = cnt;
        cnt++;
        if (c % 64 == 0) begin
          s_dig = digits; s_dp = dp; s_bl = blank; s_lz = lz_suppress; s_br = brightness;
        end
        slot = c % 16;
        di   = (c / 16) % 4;
        supp = s_lz && (di > 0) && ((s_dig >> (4 * di)) == 16'h0);
        on   = !s_bl[di] && !supp && ((slot / 4) < int'(s_br));
        e_fs = (c % 64 == 0);
        if (on) begin
          e_sel = ~(4'b0001 << di);
          e_seg = ~(seg_tab[s_dig[4*di +: 4]] | {s_dp[di], 7'b0});
        end else begin
          e_sel = 4'hF;
          e_seg = 8'hFF;
        end
        last_c = c;
      end
      #1;
      check("model.select", 32'(select), 32'(e_sel));
      check("model.segments", 32'(segments), 32'(e_seg));
      check("model.frame_start", 32'(frame_start), 32'(e_fs));
    end
  end

  initial begin : stim
    digits = '0; dp = '0; blank = '0; lz_suppress = 1'b0; brightness = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 lit("reset", 4'hF, 8'hFF, 1'b0);

    @(negedge clk);
    digits = 16'h1234; brightness = 2'd3; reset_n = 1'b1;
    goto(0);  lit("t2_slot0", 4'hE, 8'h99, 1'b1);
    goto(12); lit("t2_phase3", 4'hF, 8'hFF, 1'b0);
    goto(16); lit("t2_slot1", 4'hD, 8'hB0, 1'b0);
    goto(20);
    @(negedge clk);
    digits = 16'hABCD;
    goto(32); lit("t5_slot2_old", 4'hB, 8'hA4, 1'b0);
    goto(48); lit("t5_slot3_old", 4'h7, 8'hF9, 1'b0);
    goto(64); lit("t5_new_frame", 4'hE, 8'hA1, 1'b1);

    @(negedge clk);
    digits = 16'h0005; lz_suppress = 1'b1;
    goto(128); lit("t3_lz_d0", 4'hE, 8'h92, 1'b1);
    goto(144); lit("t3_lz_d1", 4'hF, 8'hFF, 1'b0);
    @(negedge clk);
    digits = 16'h0000;
    goto(192); lit("t3_zero_d0", 4'hE, 8'hC0, 1'b1);
    goto(208); lit("t3_zero_d1", 4'hF, 8'hFF, 1'b0);
    @(negedge clk);
    dp = 4'h1;
    goto(256); lit("t3_zero_dp", 4'hE, 8'h40, 1'b1);

    @(negedge clk);
    dp = '0; lz_suppress = 1'b0; digits = 16'h8421; brightness = 2'd1;
    goto(320); lit("t4_b1_phase0", 4'hE, 8'hF9, 1'b1);
    goto(324); lit("t4_b1_phase1", 4'hF, 8'hFF, 1'b0);
    @(negedge clk);
    brightness = 2'd0;
    goto(384); lit("t4_b0", 4'hF, 8'hFF, 1'b1);

    for (int k = 0; k < 640; k++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        digits      = 16'($urandom);
        dp          = 4'($urandom);
        blank       = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
        lz_suppress = 1'($urandom);
        brightness  = 2'($urandom);
        if ($urandom_range(3) == 0) digits[15:8] = 8'h00;
      end
    end

    goto(1061);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #2 lit("t6_reset_mid", 4'hF, 8'hFF, 1'b0);
    @(negedge clk);
    reset_n = 1'b1; digits = 16'h00C0; lz_suppress = 1'b1; brightness = 2'd2;
    blank = '0; dp = '0;
    goto(0);  lit("t6_restart_d0", 4'hE, 8'hC0, 1'b1);
    goto(16); lit("t6_restart_d1", 4'hD, 8'hC6, 1'b0);
    goto(32); lit("t6_restart_d2", 4'hF, 8'hFF, 1'b0);

    repeat (4) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
